// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification for the
// multi-cycle ALU/accumulator.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_PASS_A = 4'b0000;
  localparam opcode_t OP_SUB    = 4'b0001;
  localparam opcode_t OP_PASS_B = 4'b0010;
  localparam opcode_t OP_ADD    = 4'b0011;
  localparam opcode_t OP_NAND   = 4'b0100;
  localparam opcode_t OP_ADC    = 4'b0101;
  localparam opcode_t OP_SHL    = 4'b0110;
  localparam opcode_t OP_SHR    = 4'b0111;
  localparam opcode_t OP_MUL    = 4'b1000;
  localparam opcode_t OP_CMP    = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  typedef struct packed {
    logic wr_flags;
    logic wr_accu;
  } op_class_t;

  // Opcodes above CMP are NOPs; CMP updates flags/DataOut but not Accu.
  function automatic op_class_t op_classify(input opcode_t op);
    op_class_t cls;
    cls.wr_flags = (op <= OP_CMP);
    cls.wr_accu  = (op <= OP_MUL);
    return cls;
  endfunction

endpackage

// File: rtl/mul_secuencial.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps.
// product_c is the product including the current step's partial term.
module mul_secuencial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               finish_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_c,
  output logic               last_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    addend;

  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    product_c = prod_q + addend;
    last_c    = (cnt_q == CW'(WIDTH - 1));
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = product_c;
      cnt_d    = finish_i ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_acumulador_n.sv
// WIDTH-bit accumulator ALU with registered Z/C flags; single-cycle ops plus
// a WIDTH-cycle multiply reported through busy/done.
module alu_acumulador_n
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [3:0]       Select,
  input  logic             start,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] Accu,
  output logic             Z,
  output logic             C,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  logic             rst_sync_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] accu_q, accu_d, dout_q, dout_d;
  logic             z_q, z_d, c_q, c_d, busy_q, busy_d, done_q, done_d;

  logic [W1-1:0]    sum_add, sum_adc, diff;
  logic [WIDTH-1:0] res;
  logic             cres;
  op_class_t        cls;
  logic             mul_load, mul_step, mul_finish, mul_last;
  logic [PW-1:0]    mul_prod;

  // Assert immediately, release on the next clk edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  mul_secuencial #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_sync_q),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .finish_i  (mul_finish),
    .a_i       (accu_q),
    .b_i       (DataIn),
    .product_c (mul_prod),
    .last_c    (mul_last)
  );

  always_comb begin
    state_d    = state_q;
    accu_d     = accu_q;
    dout_d     = dout_q;
    z_d        = z_q;
    c_d        = c_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    mul_finish = 1'b0;
    res        = '0;
    cres       = 1'b0;
    cls        = op_classify(Select);
    sum_add    = {1'b0, accu_q} + {1'b0, DataIn};
    sum_adc    = sum_add + W1'(c_q);
    diff       = {1'b0, accu_q} - {1'b0, DataIn};

    case (Select)
      OP_PASS_A:      res = accu_q;
      OP_SUB, OP_CMP: {cres, res} = diff;
      OP_PASS_B:      res = DataIn;
      OP_ADD:         {cres, res} = sum_add;
      OP_NAND:        res = ~(accu_q & DataIn);
      OP_ADC:         {cres, res} = sum_adc;
      OP_SHL:         {cres, res} = {accu_q, 1'b0};
      OP_SHR: begin
        res  = accu_q >> 1;
        cres = accu_q[0];
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (Select == OP_MUL) begin
            state_d  = ST_MUL;
            busy_d   = 1'b1;
            mul_load = 1'b1;
          end else begin
            state_d = ST_EXEC;
            done_d  = 1'b1;
            if (cls.wr_flags) begin
              dout_d = res;
              z_d    = (res == '0);
              c_d    = cres;
            end
            if (cls.wr_accu) accu_d = res;
          end
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          mul_finish = 1'b1;
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          accu_d     = mul_prod[WIDTH-1:0];
          dout_d     = mul_prod[WIDTH-1:0];
          z_d        = (mul_prod[WIDTH-1:0] == '0);
          c_d        = |mul_prod[PW-1:WIDTH];
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= ST_IDLE;
      accu_q  <= '0;
      dout_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      accu_q  <= accu_d;
      dout_q  <= dout_d;
      z_q     <= z_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Accu    = accu_q;
  assign DataOut = dout_q;
  assign Z       = z_q;
  assign C       = c_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_acumulador_n.sv
// Directed bench for alu_acumulador_n: a WIDTH=4 and a WIDTH=8 instance.
module tb_alu_acumulador_n;
  import alu_pkg::*;

  logic       clk, reset;
  logic [3:0] din4, sel4, dout4, accu4;
  logic       st4, z4, c4, busy4, done4;
  logic [7:0] din8, dout8, accu8;
  logic [3:0] sel8;
  logic       st8, z8, c8, busy8, done8;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          n;

  alu_acumulador_n #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .DataIn(din4), .Select(sel4), .start(st4),
    .DataOut(dout4), .Accu(accu4), .Z(z4), .C(c4), .busy(busy4), .done(done4)
  );

  alu_acumulador_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .DataIn(din8), .Select(sel8), .start(st8),
    .DataOut(dout8), .Accu(accu8), .Z(z8), .C(c8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one start at a negedge, drop it after the accepting edge.
  task automatic issue(input bit w8, input logic [3:0] sel, input logic [7:0] b);
    if (w8) begin
      sel8 = sel; din8 = b; st8 = 1'b1;
    end else begin
      sel4 = sel; din4 = b[3:0]; st4 = 1'b1;
    end
    @(negedge clk);
    st4 = 1'b0;
    st8 = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
  endtask

  // Count busy cycles; pulse a stray PASS_B 0 start mid-multiply.
  task automatic run_mul(input bit w8, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(w8 ? busy8 : busy4)) break;
      chk("busy_done_excl", 16'(w8 ? done8 : done4), 16'h0);
      cnt++;
      if (i == 0) begin
        if (w8) begin sel8 = OP_PASS_B; din8 = '0; st8 = 1'b1; end
        else    begin sel4 = OP_PASS_B; din4 = '0; st4 = 1'b1; end
      end else if (i == 1) begin
        st4 = 1'b0; st8 = 1'b0;
      end
      @(negedge clk);
    end
    st4 = 1'b0;
    st8 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    st4 = 1'b0; sel4 = '0; din4 = '0;
    st8 = 1'b0; sel8 = '0; din8 = '0;
    repeat (2) @(negedge clk);

    chk("rst_accu4", 16'(accu4), 16'h0);
    chk("rst_dout4", 16'(dout4), 16'h0);
    chk("rst_zc4",   16'({z4, c4}), 16'h0);
    chk("rst_bd4",   16'({busy4, done4}), 16'h0);
    chk("rst_accu8", 16'(accu8), 16'h0);
    chk("rst_bd8",   16'({busy8, done8}), 16'h0);

    reset = 1'b1;
    gap();
    issue(1'b0, OP_PASS_B, 8'h09);
    chk("passb_accu", 16'(accu4), 16'h9);
    chk("passb_dout", 16'(dout4), 16'h9);
    chk("passb_zc",   16'({z4, c4}), 16'h0);
    chk("passb_done", 16'(done4), 16'h1);
    gap();
    chk("passb_done_low", 16'(done4), 16'h0);

    issue(1'b0, OP_PASS_B, 8'h0F); gap();
    issue(1'b0, OP_ADD, 8'h01);
    chk("add_accu", 16'(accu4), 16'h0);
    chk("add_zc",   16'({z4, c4}), 16'h3);
    gap();
    issue(1'b0, OP_ADC, 8'h02);
    chk("adc_accu", 16'(accu4), 16'h3);
    chk("adc_zc",   16'({z4, c4}), 16'h0);
    gap();

    issue(1'b0, OP_SUB, 8'h05);
    chk("sub_accu", 16'(accu4), 16'hE);
    chk("sub_zc",   16'({z4, c4}), 16'h1);
    gap();
    issue(1'b0, OP_CMP, 8'h0E);
    chk("cmp_accu", 16'(accu4), 16'hE);
    chk("cmp_dout", 16'(dout4), 16'h0);
    chk("cmp_zc",   16'({z4, c4}), 16'h2);
    gap();
    issue(1'b0, OP_PASS_A, 8'h03);
    chk("passa_dout", 16'(dout4), 16'hE);
    chk("passa_zc",   16'({z4, c4}), 16'h0);
    gap();

    // start held across the EXEC cycle must not re-execute
    sel4 = OP_ADD; din4 = 4'h1; st4 = 1'b1;
    gap();
    chk("hold_accu1", 16'(accu4), 16'hF);
    gap();
    chk("hold_accu2", 16'(accu4), 16'hF);
    chk("hold_done",  16'(done4), 16'h0);
    st4 = 1'b0;

    issue(1'b0, 4'b1100, 8'h03);
    chk("nop_accu", 16'(accu4), 16'hF);
    chk("nop_dout", 16'(dout4), 16'hF);
    chk("nop_done", 16'(done4), 16'h1);
    gap();
    issue(1'b0, OP_NAND, 8'h05);
    chk("nand_accu", 16'(accu4), 16'hA);
    chk("nand_zc",   16'({z4, c4}), 16'h0);
    gap();

    issue(1'b0, OP_PASS_B, 8'h07); gap();
    issue(1'b0, OP_MUL, 8'h06);
    run_mul(1'b0, n);
    chk("mul4_busy_cycles", 16'(n), 16'd4);
    chk("mul4_done", 16'(done4), 16'h1);
    chk("mul4_accu", 16'(accu4), 16'hA);
    chk("mul4_dout", 16'(dout4), 16'hA);
    chk("mul4_zc",   16'({z4, c4}), 16'h1);
    gap();
    chk("mul4_done_low", 16'(done4), 16'h0);
    chk("mul4_accu_kept", 16'(accu4), 16'hA);

    issue(1'b0, OP_PASS_B, 8'h03); gap();
    issue(1'b0, OP_MUL, 8'h03);
    gap();
    reset = 1'b0;
    #1;
    chk("abort_accu", 16'(accu4), 16'h0);
    chk("abort_dout", 16'(dout4), 16'h0);
    chk("abort_zc",   16'({z4, c4}), 16'h0);
    chk("abort_bd",   16'({busy4, done4}), 16'h0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 16'(done4), 16'h0);
    reset = 1'b1;
    gap();
    chk("rel_bd",   16'({busy4, done4}), 16'h0);
    chk("rel_accu", 16'(accu4), 16'h0);
    issue(1'b0, OP_PASS_B, 8'h05);
    chk("rel_passb_accu", 16'(accu4), 16'h5);
    chk("rel_passb_done", 16'(done4), 16'h1);
    gap();

    issue(1'b1, OP_PASS_B, 8'h81); gap();
    issue(1'b1, OP_SHL, 8'h00);
    chk("shl8_accu", 16'(accu8), 16'h02);
    chk("shl8_zc",   16'({z8, c8}), 16'h1);
    gap();
    issue(1'b1, OP_PASS_B, 8'h01); gap();
    issue(1'b1, OP_SHR, 8'h00);
    chk("shr8_accu", 16'(accu8), 16'h00);
    chk("shr8_zc",   16'({z8, c8}), 16'h3);
    gap();
    issue(1'b1, OP_PASS_B, 8'h10); gap();
    issue(1'b1, OP_MUL, 8'h10);
    run_mul(1'b1, n);
    chk("mul8_busy_cycles", 16'(n), 16'd8);
    chk("mul8_done", 16'(done8), 16'h1);
    chk("mul8_accu", 16'(accu8), 16'h00);
    chk("mul8_zc",   16'({z8, c8}), 16'h3);
    gap();
    chk("mul8_done_low", 16'(done8), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
